// File: rtl/planarize_engine.sv
// planarize_engine: converts interleaved two-pixel RGB groups into R, G and B planes in one memory.
// Optional PLANARIZE_CHECKSUM_EN adds a running 16-bit sum of every written word.
module planarize_engine #(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       width,
    input  logic [15:0]       height,
    input  logic              start,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [15:0]       r_data,
    output logic [ADDR_W-1:0] w_addr,
    output logic [15:0]       wdata,
    output logic              wen,
    output logic              busy,
    output logic              done
`ifdef PLANARIZE_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    typedef enum logic [3:0] {IDLE, RD0, RD1, RD2, CAP, WR_R, WR_G, WR_B, DONE} state_t;

    state_t            state, next;
    logic [ADDR_W-1:0] n, k, base, n_in;
    logic [15:0]       w0, w1, w2, r_word, g_word, b_word;
    logic              last;

    // Group count from a full 32-bit product so large images do not wrap early.
    assign n_in   = ADDR_W'((32'(width) * 32'(height)) >> 1);
    assign r_word = {w2[15:8], w0[7:0]};
    assign g_word = {w1[7:0], w0[15:8]};
    assign b_word = {w1[15:8], w2[7:0]};
    assign last   = k == n - 1'b1;
    assign busy   = state != IDLE;
    assign done   = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next   = state;
        r_addr = '0;
        w_addr = '0;
        wdata  = '0;
        wen    = 1'b0;
        unique case (state)
            IDLE: if (start) next = (n_in == '0) ? DONE : RD0;
            RD0: begin
                r_addr = base;
                next   = RD1;
            end
            RD1: begin
                r_addr = base + ADDR_W'(1);
                next   = RD2;
            end
            RD2: begin
                r_addr = base + ADDR_W'(2);
                next   = CAP;
            end
            CAP: next = WR_R;
            WR_R: begin
                wen    = 1'b1;
                w_addr = k;
                wdata  = r_word;
                next   = WR_G;
            end
            WR_G: begin
                wen    = 1'b1;
                w_addr = n + k;
                wdata  = g_word;
                next   = WR_B;
            end
            WR_B: begin
                wen    = 1'b1;
                w_addr = n + n + k;
                wdata  = b_word;
                next   = last ? DONE : RD0;
            end
            DONE: next = IDLE;
            default: next = IDLE;
        endcase
    end

    // base tracks the source address 3N+3k of the current group.
    always_ff @(posedge clk) begin
        if (rst) begin
            n    <= '0;
            k    <= '0;
            base <= '0;
            w0   <= '0;
            w1   <= '0;
            w2   <= '0;
        end else begin
            if (state == IDLE && start) begin
                n    <= n_in;
                k    <= '0;
                base <= ADDR_W'(3 * n_in);
            end
            if (state == RD1) w0 <= r_data;
            if (state == RD2) w1 <= r_data;
            if (state == CAP) w2 <= r_data;
            if (state == WR_B) begin
                k    <= k + 1'b1;
                base <= base + ADDR_W'(3);
            end
        end
    end

`ifdef PLANARIZE_CHECKSUM_EN
    // All three words of a group are folded in at once, in the group's last write cycle.
    always_ff @(posedge clk) begin
        if (rst)                         checksum <= '0;
        else if (state == IDLE && start) checksum <= '0;
        else if (state == WR_B)          checksum <= checksum + r_word + g_word + b_word;
    end
`endif

endmodule

// File: tb/tb_planarize_engine.sv
// tb_planarize_engine: random and directed conversions checked against a pixel-level plane model.
module tb_planarize_engine;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   width = '0, height = '0, r_data = '0, wdata;
    logic [AW-1:0] r_addr, w_addr, rd_q = '0;
    logic          wen, busy, done;
`ifdef PLANARIZE_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    planarize_engine #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .width(width), .height(height), .start(start),
        .r_addr(r_addr), .r_data(r_data), .w_addr(w_addr), .wdata(wdata),
        .wen(wen), .busy(busy), .done(done)
`ifdef PLANARIZE_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] mem [int];
    int          wa_q[$], rlog[$], ea_q[$], er_q[$];
    logic [15:0] wd_q[$], ed_q[$];
    int          done_cnt, busy_cnt, zero_viol;
    int          errors = 0, checks = 0;

    always @(posedge clk) r_data <= mem.exists(int'(rd_q)) ? mem[int'(rd_q)] : 16'h0;

    always @(negedge clk) begin
        rd_q = r_addr;
        if (wen) begin
            wa_q.push_back(int'(w_addr));
            wd_q.push_back(wdata);
            mem[int'(w_addr)] = wdata;
        end
        if (r_addr != '0) rlog.push_back(int'(r_addr));
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (!wen && (w_addr != '0 || wdata != '0)) zero_viol++;
    end

    function automatic void fill_src(input int n);
        mem.delete();
        for (int i = 3 * n; i < 6 * n; i++) mem[i] = 16'($urandom);
    endfunction

    // Expected write stream built from the pixels: plane word = {pixel1 channel, pixel0 channel}.
    function automatic void build_model(input int n);
        logic [15:0] a, b, c;
        logic [7:0]  r0, g0, b0, r1, g1, b1;
        ea_q.delete(); ed_q.delete(); er_q.delete();
        for (int k = 0; k < n; k++) begin
            a = mem[3*n+3*k]; b = mem[3*n+3*k+1]; c = mem[3*n+3*k+2];
            r0 = a[7:0]; g0 = a[15:8]; b0 = c[7:0];
            r1 = c[15:8]; g1 = b[7:0]; b1 = b[15:8];
            ea_q.push_back(k);       ed_q.push_back({r1, r0});
            ea_q.push_back(n + k);   ed_q.push_back({g1, g0});
            ea_q.push_back(2*n + k); ed_q.push_back({b1, b0});
            for (int j = 0; j < 3; j++) er_q.push_back(3*n + 3*k + j);
        end
    endfunction

    task automatic convert(input logic [15:0] w, input logic [15:0] h, input int inj, output int lat);
        int lim;
        lim = 7 * (int'(w) * int'(h) / 2) + 50;
        wa_q.delete(); wd_q.delete(); rlog.delete();
        done_cnt = 0; busy_cnt = 0; zero_viol = 0;
        @(negedge clk);
        width = w; height = h; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < lim) begin
            start = (lat == inj);
            if (lat == inj) width = 16'd9;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b expected 0", wen); end
        checks++; if (r_addr !== '0) begin errors++; $display("FAIL reset_r_addr: got %0h expected 0", r_addr); end
        checks++; if (w_addr !== '0) begin errors++; $display("FAIL reset_w_addr: got %0h expected 0", w_addr); end
        checks++; if (wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", wdata); end
`ifdef PLANARIZE_CHECKSUM_EN
        checks++; if (checksum !== '0) begin errors++; $display("FAIL reset_checksum: got %0h expected 0", checksum); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int lat;
        logic [15:0] s;
        mem.delete();
        mem[3] = 16'h2211; mem[4] = 16'h4433; mem[5] = 16'h6655;
        build_model(1);
        convert(16'd2, 16'd1, -1, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL dir_latency: got %0d expected 8", lat); end
        checks++; if (wa_q.size() !== 3) begin errors++; $display("FAIL dir_wcount: got %0d expected 3", wa_q.size()); end
        checks++; if (mem[0] !== 16'h6611) begin errors++; $display("FAIL dir_r: got %0h expected 6611", mem[0]); end
        checks++; if (mem[1] !== 16'h3322) begin errors++; $display("FAIL dir_g: got %0h expected 3322", mem[1]); end
        checks++; if (mem[2] !== 16'h4455) begin errors++; $display("FAIL dir_b: got %0h expected 4455", mem[2]); end
        s = 16'h6611 + 16'h3322 + 16'h4455;
`ifdef PLANARIZE_CHECKSUM_EN
        checks++; if (checksum !== s) begin errors++; $display("FAIL dir_checksum: got %0h expected %0h", checksum, s); end
`else
        if (s == 16'h0) $display("note: zero directed sum");
`endif
    endtask

    task automatic test_random();
        int lat, n;
        logic [15:0] w, h, s;
        for (int it = 0; it < 8; it++) begin
            w = (it == 0) ? 16'd4 : 16'($urandom_range(1, 7));
            h = (it == 0) ? 16'd2 : 16'($urandom_range(1, 4));
            n = int'(w) * int'(h) / 2;
            fill_src(n);
            build_model(n);
            convert(w, h, -1, lat);
            checks++; if (lat !== 7*n+1) begin errors++; $display("FAIL rnd_latency: got %0d expected %0d", lat, 7*n+1); end
            checks++; if (wa_q.size() !== 3*n) begin errors++; $display("FAIL rnd_wcount: got %0d expected %0d", wa_q.size(), 3*n); end
            for (int i = 0; i < wa_q.size() && i < ea_q.size(); i++) begin
                checks++;
                if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) begin
                    errors++;
                    $display("FAIL rnd_write%0d: got %0h@%0d expected %0h@%0d", i, wd_q[i], wa_q[i], ed_q[i], ea_q[i]);
                end
            end
            checks++; if (rlog != er_q) begin errors++; $display("FAIL rnd_reads: got %0d reads expected %0d in %0d..%0d", rlog.size(), er_q.size(), 3*n, 6*n-1); end
            checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rnd_done_cnt: got %0d expected 1", done_cnt); end
            checks++; if (busy_cnt !== 7*n+1) begin errors++; $display("FAIL rnd_busy_cnt: got %0d expected %0d", busy_cnt, 7*n+1); end
            checks++; if (zero_viol !== 0) begin errors++; $display("FAIL rnd_idle_zero: got %0d expected 0", zero_viol); end
            s = '0;
            foreach (ed_q[i]) s += ed_q[i];
`ifdef PLANARIZE_CHECKSUM_EN
            checks++; if (checksum !== s) begin errors++; $display("FAIL rnd_checksum: got %0h expected %0h", checksum, s); end
`endif
        end
    endtask

    task automatic test_zero();
        int lat;
        logic [15:0] dims [2][2];
        dims[0][0] = 16'd1; dims[0][1] = 16'd1;
        dims[1][0] = 16'd0; dims[1][1] = 16'd5;
        for (int i = 0; i < 2; i++) begin
            mem.delete();
            convert(dims[i][0], dims[i][1], -1, lat);
            checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
            checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL zero_writes: got %0d expected 0", wa_q.size()); end
            checks++; if (rlog.size() !== 0) begin errors++; $display("FAIL zero_reads: got %0d expected 0", rlog.size()); end
            checks++; if (busy_cnt !== 1) begin errors++; $display("FAIL zero_busy: got %0d expected 1", busy_cnt); end
            checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done: got %0d expected 1", done_cnt); end
`ifdef PLANARIZE_CHECKSUM_EN
            checks++; if (checksum !== '0) begin errors++; $display("FAIL zero_checksum: got %0h expected 0", checksum); end
`endif
        end
    endtask

    task automatic test_abort();
        int t, lat;
        fill_src(4);
        build_model(4);
        wa_q.delete(); wd_q.delete(); done_cnt = 0;
        @(negedge clk);
        width = 16'd4; height = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 1;
        while (!(wen && w_addr == AW'(5)) && t < 60) begin
            @(negedge clk);
            t++;
        end
        checks++; if (t !== 13) begin errors++; $display("FAIL abort_wr_g1_cycle: got %0d expected 13", t); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL abort_wen: got %0b expected 0", wen); end
        repeat (40) @(negedge clk);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
        checks++; if (wa_q.size() !== 5) begin errors++; $display("FAIL abort_wcount: got %0d expected 5", wa_q.size()); end
        convert(16'd4, 16'd2, -1, lat);
        checks++; if (lat !== 29) begin errors++; $display("FAIL abort_rerun_latency: got %0d expected 29", lat); end
        checks++; if (wa_q != ea_q || wd_q != ed_q) begin errors++; $display("FAIL abort_rerun_writes: got %0d writes expected %0d", wa_q.size(), ea_q.size()); end
    endtask

    task automatic test_start_ignored();
        int lat;
        fill_src(4);
        build_model(4);
        convert(16'd4, 16'd2, 5, lat);
        checks++; if (lat !== 29) begin errors++; $display("FAIL ign_latency: got %0d expected 29", lat); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (wa_q.size() !== 12) begin errors++; $display("FAIL ign_wcount: got %0d expected 12", wa_q.size()); end
        checks++; if (wa_q != ea_q || wd_q != ed_q) begin errors++; $display("FAIL ign_writes: stream differs from model (%0d writes)", wa_q.size()); end
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle_after: got busy=%0b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_zero();
        test_abort();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
